// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the Vedic multiplier family.
package vedic_pkg;

  localparam int VEDIC_LATENCY = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // True only for power-of-two operand widths the recursive core can split down to 2x2 cells.
  function automatic bit width_ok(input int width);
    return (width >= 2) && (width <= 32) && ((1 << clog2(width)) == width);
  endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational NxN Urdhva-Tiryakbhyam multiplier: recursive split into four
// N/2 sub-products, terminating in the 2x2 Vedic cell (or a plain AND at N=1).
module vedic_core #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  generate
    if (N == 1) begin : g_bit
      assign p_o = {1'b0, a_i[0] & b_i[0]};
    end else if (N == 2) begin : g_cell
      logic crossA, crossB, crossCarry, highBit;
      assign crossA     = a_i[1] & b_i[0];
      assign crossB     = a_i[0] & b_i[1];
      assign crossCarry = crossA & crossB;
      assign highBit    = a_i[1] & b_i[1];
      assign p_o = {highBit & crossCarry, highBit ^ crossCarry, crossA ^ crossB, a_i[0] & b_i[0]};
    end else begin : g_rec
      localparam int H = N / 2;
      logic [N-1:0]   ll, lh, hl, hh;
      logic [N:0]     midSum;
      logic [2*N-1:0] midShifted;

      vedic_core #(.N(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
      vedic_core #(.N(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(lh));
      vedic_core #(.N(H)) u_hl (.a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
      vedic_core #(.N(H)) u_hh (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(hh));

      assign midSum     = {1'b0, lh} + {1'b0, hl};
      assign midShifted = {{(N-1){1'b0}}, midSum} << H;
      assign p_o        = {hh, ll} + midShifted;
    end
  endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// Two-stage pipelined Vedic multiplier with valid/ready backpressure and a
// pass-through tag. Define VEDIC_MULT_SIGNED_EN for two's-complement operands.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H = WIDTH / 2;

  generate
    if (!width_ok(WIDTH) || TAG_W < 1) begin : g_badParam
      $error("vedic_mult_pipe: WIDTH must be a power of two in 2..32 and TAG_W >= 1");
    end
  endgenerate

  logic [WIDTH-1:0]   opA, opB;
  logic [WIDTH-1:0]   llPart, lhPart, hlPart, hhPart;
  logic [WIDTH-1:0]   ll_q, lh_q, hl_q, hh_q, ll_d, lh_d, hl_d, hh_d;
  logic [TAG_W-1:0]   s1Tag_q, s1Tag_d, outTag_q, outTag_d;
  logic               s1Valid_q, s1Valid_d, s2Valid_q, s2Valid_d;
  logic [2*WIDTH-1:0] outR_q, outR_d;
  logic [WIDTH:0]     midSum;
  logic [2*WIDTH-1:0] prodMag, prodFinal;
  logic               s2Advance, accept;

`ifdef VEDIC_MULT_SIGNED_EN
  logic sign_q, sign_d, signIn;
  assign opA    = in_a[WIDTH-1] ? (~in_a + 1'b1) : in_a;
  assign opB    = in_b[WIDTH-1] ? (~in_b + 1'b1) : in_b;
  assign signIn = in_a[WIDTH-1] ^ in_b[WIDTH-1];
`else
  assign opA = in_a;
  assign opB = in_b;
`endif

  vedic_core #(.N(H)) u_ll (.a_i(opA[H-1:0]),     .b_i(opB[H-1:0]),     .p_o(llPart));
  vedic_core #(.N(H)) u_lh (.a_i(opA[H-1:0]),     .b_i(opB[WIDTH-1:H]), .p_o(lhPart));
  vedic_core #(.N(H)) u_hl (.a_i(opA[WIDTH-1:H]), .b_i(opB[H-1:0]),     .p_o(hlPart));
  vedic_core #(.N(H)) u_hh (.a_i(opA[WIDTH-1:H]), .b_i(opB[WIDTH-1:H]), .p_o(hhPart));

  assign midSum  = {1'b0, lh_q} + {1'b0, hl_q};
  assign prodMag = {hh_q, ll_q} + ({{(WIDTH-1){1'b0}}, midSum} << H);
`ifdef VEDIC_MULT_SIGNED_EN
  assign prodFinal = sign_q ? (~prodMag + 1'b1) : prodMag;
`else
  assign prodFinal = prodMag;
`endif

  assign s2Advance = !s2Valid_q || out_ready;
  assign in_ready  = !s1Valid_q || s2Advance;
  assign accept    = in_valid && in_ready;

  // Next-state: drain S1 into S2 whenever S2 can move, then refill S1 on accept.
  always_comb begin
    s1Valid_d = s1Valid_q;
    ll_d      = ll_q;
    lh_d      = lh_q;
    hl_d      = hl_q;
    hh_d      = hh_q;
    s1Tag_d   = s1Tag_q;
    s2Valid_d = s2Valid_q;
    outR_d    = outR_q;
    outTag_d  = outTag_q;
`ifdef VEDIC_MULT_SIGNED_EN
    sign_d    = sign_q;
`endif
    if (s2Advance) begin
      s2Valid_d = s1Valid_q;
      s1Valid_d = 1'b0;
      if (s1Valid_q) begin
        outR_d   = prodFinal;
        outTag_d = s1Tag_q;
      end
    end
    if (accept) begin
      s1Valid_d = 1'b1;
      ll_d      = llPart;
      lh_d      = lhPart;
      hl_d      = hlPart;
      hh_d      = hhPart;
      s1Tag_d   = in_tag;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_d    = signIn;
`endif
    end
  end

  // Pipeline registers; reset discards every in-flight operation at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      ll_q      <= '0;
      lh_q      <= '0;
      hl_q      <= '0;
      hh_q      <= '0;
      s1Tag_q   <= '0;
      s2Valid_q <= 1'b0;
      outR_q    <= '0;
      outTag_q  <= '0;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      s1Valid_q <= s1Valid_d;
      ll_q      <= ll_d;
      lh_q      <= lh_d;
      hl_q      <= hl_d;
      hh_q      <= hh_d;
      s1Tag_q   <= s1Tag_d;
      s2Valid_q <= s2Valid_d;
      outR_q    <= outR_d;
      outTag_q  <= outTag_d;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign out_valid = s2Valid_q;
  assign out_r     = outR_q;
  assign out_tag   = outTag_q;

endmodule
